// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: programmed count of frames, each a programmed number of
// beats of incrementing data, with an optional idle gap between frames and full backpressure support.
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t                 state_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [LEN_WIDTH-1:0]   beat_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [GAP_WIDTH-1:0]   gap_r;
    logic [GAP_WIDTH-1:0]   gap_cnt_r;
    logic                   sof_r;
    logic                   xfer_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    assign xfer_s       = m_axis_tvalid && m_axis_tready;
    assign m_axis_tuser = USER_WIDTH'(sof_r);

    // Every beat carries all bytes, so tkeep is all ones whether or not the sink uses it.
    if (KEEP_ENABLE) begin : g_keep
        assign m_axis_tkeep = {KEEP_WIDTH{1'b1}};
    end else begin : g_no_keep
        assign m_axis_tkeep = {KEEP_WIDTH{1'b1}};
    end

    // Frame sequencer with all stream and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            len_r         <= LEN_WIDTH'(0);
            beat_r        <= LEN_WIDTH'(0);
            count_r       <= CNT_WIDTH'(0);
            gap_r         <= GAP_WIDTH'(0);
            gap_cnt_r     <= GAP_WIDTH'(0);
            sof_r         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frames_sent   <= CNT_WIDTH'(0);
            m_axis_tdata  <= DATA_WIDTH'(0);
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_start) begin
                        len_r        <= cfg_frame_len;
                        count_r      <= cfg_frame_count;
                        gap_r        <= cfg_gap;
                        frames_sent  <= CNT_WIDTH'(0);
                        busy         <= 1'b1;
                        m_axis_tdata <= cfg_seed;
                        beat_r       <= LEN_WIDTH'(0);
                        if (cfg_frame_len == LEN_WIDTH'(0) || cfg_frame_count == CNT_WIDTH'(0)) begin
                            state_r <= FIN;
                        end else begin
                            state_r       <= SEND;
                            m_axis_tvalid <= 1'b1;
                            sof_r         <= 1'b1;
                            m_axis_tlast  <= (cfg_frame_len == LEN_WIDTH'(1));
                        end
                    end
                end
                SEND: begin
                    if (xfer_s) begin
                        // Global beat index never restarts between frames.
                        m_axis_tdata <= m_axis_tdata + DATA_WIDTH'(1);
                        if (m_axis_tlast) begin
                            frames_sent <= sat_inc(frames_sent);
                            beat_r      <= LEN_WIDTH'(0);
                            if (frames_sent + CNT_WIDTH'(1) == count_r) begin
                                state_r       <= FIN;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                sof_r         <= 1'b0;
                                done          <= 1'b1;
                                busy          <= 1'b0;
                            end else if (gap_r == GAP_WIDTH'(0)) begin
                                sof_r        <= 1'b1;
                                m_axis_tlast <= (len_r == LEN_WIDTH'(1));
                            end else begin
                                state_r       <= GAP;
                                gap_cnt_r     <= gap_r;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                sof_r         <= 1'b0;
                            end
                        end else begin
                            beat_r       <= beat_r + LEN_WIDTH'(1);
                            sof_r        <= 1'b0;
                            m_axis_tlast <= (beat_r + LEN_WIDTH'(1) == len_r - LEN_WIDTH'(1));
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_WIDTH'(1)) begin
                        state_r       <= SEND;
                        m_axis_tvalid <= 1'b1;
                        sof_r         <= 1'b1;
                        m_axis_tlast  <= (len_r == LEN_WIDTH'(1));
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
                    end
                end
                FIN: begin
                    // Arriving from SEND, done is already up; arriving from IDLE, raise it now.
                    if (done) begin
                        done    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: stimulus pushes expected beats, a negedge monitor
// pops and compares every transfer, and checks stall stability, gaps and status outputs.
module tb_axis_frame_gen;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_frame_len;
    logic [15:0] cfg_frame_count;
    logic [7:0]  cfg_gap;
    logic [7:0]  cfg_seed;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;
    logic [7:0]  m_axis_tdata;
    logic [0:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;

    axis_frame_gen dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_frame_len(cfg_frame_len),
        .cfg_frame_count(cfg_frame_count), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
        .busy(busy), .done(done), .frames_sent(frames_sent), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    last_xfer = 0;
    int    exp_fs = 0;
    int    exp_gap = 0;
    int    low_run = 0;
    bit    pend = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;
    bit    rmode = 0;
    logic  man_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_axis_tready = rmode ? 1'($urandom_range(0, 1)) : man_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and tracks stalls and gaps.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 0;
            pend = 0;
            low_run = 0;
        end else begin
            if (busy || done) check("frames_sent", 32'(frames_sent), 32'(exp_fs));
            if (prev_stall) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_hold", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser[0]}), 32'(prev_beat));
            end
            if (pend) begin
                if (m_axis_tvalid) begin
                    check("gap_len", 32'(low_run), 32'(exp_gap));
                    pend = 0;
                end else begin
                    low_run++;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    check("tdata", 32'(m_axis_tdata), 32'(e.data));
                    check("tlast", 32'(m_axis_tlast), 32'(e.last));
                    check("tuser", 32'(m_axis_tuser), 32'(e.user));
                end
                check("tkeep", 32'(m_axis_tkeep), 32'd1);
                last_xfer = cyc;
                if (m_axis_tlast) begin
                    exp_fs++;
                    if (sb.size() != 0) begin
                        pend = 1;
                        low_run = 0;
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser[0]};
        end
    end

    task automatic set_cfg(input logic [7:0] seed, input int len, input int cnt, input int gap);
        cfg_seed = seed;
        cfg_frame_len = 16'(len);
        cfg_frame_count = 16'(cnt);
        cfg_gap = 8'(gap);
    endtask

    task automatic push_frames(input logic [7:0] seed, input int len, input int cnt);
        logic [7:0] d;
        d = seed;
        for (int f = 0; f < cnt; f++) begin
            for (int b = 0; b < len; b++) begin
                sb.push_back('{data: d, last: (b == len - 1), user: (b == 0)});
                d = d + 8'd1;
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        exp_fs = 0;
    endtask

    task automatic run(input logic [7:0] seed, input int len, input int cnt, input int gap,
                       input bit rnd, input bit poke);
        int n;
        rmode = rnd;
        exp_gap = gap;
        push_frames(seed, len, cnt);
        set_cfg(seed, len, cnt, gap);
        start_pulse();
        @(negedge clk);
        check("first_valid", 32'(m_axis_tvalid), 32'd1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 cfg_start = 1'b1;
            set_cfg(~seed, 7, 9, 0);
            @(posedge clk); #1 cfg_start = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 2000);
        check("done_seen", 32'(done), 32'd1);
        check("done_latency", 32'(cyc - last_xfer), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("fs_hold", 32'(frames_sent), 32'(cnt));
        rmode = 0;
    endtask

    task automatic run_empty(input int len, input int cnt);
        set_cfg(8'h33, len, cnt, 0);
        start_pulse();
        @(negedge clk);
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_valid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy_off", 32'(busy), 32'd0);
        check("empty_valid2", 32'(m_axis_tvalid), 32'd0);
        check("empty_fs", 32'(frames_sent), 32'd0);
        @(negedge clk);
        check("empty_done_off", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        m_axis_tready = 1'b1;
        set_cfg(8'h00, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done}), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_fs", 32'(frames_sent), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run(8'h10, 4, 1, 0, 0, 0);
        run(8'h20, 3, 3, 2, 0, 1);
        run(8'h40, 5, 2, 0, 1, 0);
        run(8'hFE, 4, 1, 0, 0, 0);
        run(8'h70, 1, 3, 1, 0, 0);
        run_empty(0, 2);
        run_empty(3, 0);

        // Reset while the third beat of an 8-beat frame is stalled.
        @(negedge clk);
        man_ready = 1'b0;
        push_frames(8'h80, 2, 1);
        sb[1].last = 1'b0;
        set_cfg(8'h80, 8, 1, 0);
        @(posedge clk); #1 cfg_start = 1'b1;
        @(negedge clk); man_ready = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        exp_fs = 0;
        @(negedge clk);
        @(negedge clk); man_ready = 1'b0;
        @(negedge clk);
        check("stall_beat2", 32'({m_axis_tvalid, m_axis_tready, m_axis_tdata}), 32'h282);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        man_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_fs", 32'(frames_sent), 32'd0);
        check("rst_mid_sb", 32'(sb.size()), 32'd0);
        run(8'h80, 3, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
- AXI4-Stream transmitter that generates frames for driving and stress-testing stream sinks such as our pipeline FIFOs.
- Emits a programmed number of frames, each a programmed number of beats long, with a deterministic incrementing data pattern.
- Inserts a programmable idle gap between frames and honours m_axis_tready backpressure exactly.
- Sits at the head of a stream path in benches and loopback/BIST logic; reports progress to control logic via status outputs.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), drive tkeep.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- USER_WIDTH, 1, tuser width.
- LEN_WIDTH, 16, width of frame length (beats).
- CNT_WIDTH, 16, width of frame count and frames_sent.
- GAP_WIDTH, 8, width of inter-frame gap (cycles).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cfg_start  input  1  start request pulse/level, sampled only in IDLE
- cfg_frame_len  input  LEN_WIDTH  beats per frame
- cfg_frame_count  input  CNT_WIDTH  frames to send
- cfg_gap  input  GAP_WIDTH  idle cycles between frames
- cfg_seed  input  DATA_WIDTH  first data value
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse
- frames_sent  output  CNT_WIDTH  frames completed since last accepted start
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tkeep  output  KEEP_WIDTH  all ones when KEEP_ENABLE, else tied all ones
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready
- m_axis_tlast  output  1  last beat of frame
- m_axis_tuser  output  USER_WIDTH  bit0 = start-of-frame marker; upper bits 0

Behaviour:
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0, busy=0, done=0, frames_sent=0; state=IDLE. Reset asserted mid-frame drops tvalid on the next edge. No partial frame is resumed.
- All outputs are registered; no combinational path from tready to any output.
- Handshake:
  - A beat transfers on a cycle with tvalid && tready.
  - While tvalid=1 and tready=0, tdata/tlast/tuser/tkeep hold stable and tvalid stays 1.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - On cfg_start=1, latch all cfg_* inputs, clear frames_sent, set busy=1.
  - If latched len==0 or count==0, go to FIN (no beats sent).
  - Otherwise go to SEND; tvalid=1 on the next cycle (start-to-first-valid latency 1 cycle).
- SEND:
  - Beat index b within frame runs 0..len-1. tuser[0]=1 only on b=0; tlast=1 only on b=len-1 (len=1 gives both on the same beat).
  - tdata = seed + global beat index since start, modulo 2^DATA_WIDTH, wrapping silently. The global index does not reset between frames.
  - On tlast transfer, frames_sent increments.
  - If frames_sent+1 == count, go to FIN.
  - Else if gap==0, continue in SEND with the next frame's first beat presented on the next cycle (back-to-back, tvalid stays 1).
  - Else go to GAP.
- GAP: tvalid=0 for exactly gap cycles, then SEND.
- FIN: done=1 for one cycle, busy=0 from the same cycle, then IDLE.
- cfg_start while busy is ignored. Changes to cfg_* while busy have no effect.
- frames_sent saturates at 2^CNT_WIDTH-1 (unreachable with count<=max, but required). It holds its value after done until the next accepted start.

Test Plan:
- seed=0x10, len=4, count=1, gap=0, tready=1 -> tdata 10,11,12,13; tuser[0]=1 on 0x10; tlast on 0x13; first tvalid 1 cycle after start; done 1 cycle after the 0x13 transfer; frames_sent=1.
- len=3, count=3, gap=2, tready=1 -> 9 beats with data seed..seed+8; exactly 2 tvalid-low cycles between frames; frames_sent steps 1,2,3; single done pulse.
- len=5, count=2, gap=0, tready toggled pseudo-randomly (50%) -> data/last/user stable during stalls; 10 transfers with no gaps in the data sequence; frames back-to-back without a tvalid drop while tready=1.
- DATA_WIDTH=8, seed=0xFE, len=4, count=1 -> tdata FE,FF,00,01 (wrap).
- len=0 or count=0 with start -> no tvalid; busy high 1 cycle, done pulse, frames_sent=0. Start pulse during busy -> ignored; sequence unchanged.
- rst asserted during beat 2 of a len=8 frame with tready=0 -> tvalid=0 next cycle; busy=0; frames_sent=0; a new start begins cleanly from seed with tuser[0]=1.
